dmem_banked: RTL and testbench
==============================

DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width of RW_Addr.
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port Req_Valid  input  1  meaning access request present.
REQ-006 SHALL have port Req_Ready  output  1  meaning block accepts a request this cycle.
REQ-007 SHALL have port MEM_W_En  input  1  meaning store (1) or load (0).
REQ-008 SHALL have port MEM_Control  input  3  meaning size/sign: MEM_BYTE, MEM_HALFWORD, MEM_WORD, MEM_BYTE_UNSIGNED, MEM_HALFWORD_UNSIGNED (definitions package encodings).
REQ-009 SHALL have port RW_Addr  input  ADDR_W  meaning byte address.
REQ-010 SHALL have port W_Data  input  32  meaning store data, least-significant bytes used.
REQ-011 SHALL have port R_Data  output  32  meaning load result, sign/zero-extended.
REQ-012 SHALL have port Resp_Valid  output  1  meaning one-cycle pulse: access complete, R_Data valid for loads.
REQ-013 SHALL have port Misaligned_Err  output  1  meaning pulses with Resp_Valid when a misaligned access is rejected.

Function
REQ-014 SHALL store data in four byte-lane banks, lane k holding byte k of each word, word index = RW_Addr[log2(DEPTH_WORDS)+1:2], upper address bits ignored.
REQ-015 SHALL accept a request when Req_Valid && Req_Ready on a rising edge.
REQ-016 SHALL implement FSM states IDLE, SPLIT, RESP: IDLE->RESP on aligned accept, IDLE->SPLIT on misaligned accept (macro enabled), SPLIT->RESP next cycle, RESP->IDLE, or RESP->RESP/SPLIT on back-to-back accept.
REQ-017 SHALL drive Req_Ready high in IDLE and RESP, low in SPLIT.
REQ-018 SHALL complete aligned accesses with Resp_Valid high exactly 1 cycle after accept.
REQ-019 SHALL write only the addressed lanes: byte = 1 lane, halfword = 2 lanes, word = 4 lanes.
REQ-020 SHALL sign-extend for MEM_BYTE/MEM_HALFWORD loads and zero-extend for unsigned variants; MEM_WORD returns all 32 bits.
REQ-021 SHALL treat alignment as: halfword needs addr[0]=0, word needs addr[1:0]=0, byte always aligned.
REQ-022 SHALL make a store visible to a load accepted the next cycle (read-after-write, no stale data).
REQ-023 SHALL wrap the second word of a split access from index DEPTH_WORDS-1 to index 0.
REQ-024 SHALL hold R_Data stable between Resp_Valid pulses; Misaligned_Err low unless REQ-032 applies.

Reset
REQ-025 SHALL, on RST low, immediately force FSM to IDLE, Resp_Valid=0, Misaligned_Err=0, R_Data=0, Req_Ready=0 while RST low.
REQ-026 SHALL NOT clear memory contents on reset.
REQ-027 SHALL, on reset during SPLIT, abort the access: first-word lanes already written remain, second-word lanes not written, no Resp_Valid.
REQ-028 SHALL ignore Req_Valid while RST low and on the first edge after release is accepted normally.

Configuration
REQ-029 SHALL use macro DMEM_MISALIGN_EN.
REQ-030 SHALL, with DMEM_MISALIGN_EN defined, split a misaligned access into two word accesses: lanes of word N in accept cycle, lanes of word N+1 in SPLIT cycle; Resp_Valid 2 cycles after accept with merged load data.
REQ-031 SHALL, with DMEM_MISALIGN_EN defined, never assert Misaligned_Err.
REQ-032 SHALL, without DMEM_MISALIGN_EN, complete a misaligned access in 1 cycle with Resp_Valid=1, Misaligned_Err=1, no lane written, R_Data=0; SPLIT state not synthesised.

Verification
REQ-033 Store byte 0x1111_11FF @0x0, then MEM_BYTE load @0x0 -> R_Data 0xFFFF_FFFF; MEM_BYTE_UNSIGNED -> 0x0000_00FF, each 1 cycle after accept.
REQ-034 Store halfword 0xF11F_F00F @0x2, load MEM_HALFWORD @0x2 -> 0xFFFF_F00F; MEM_HALFWORD_UNSIGNED -> 0x0000_F00F; byte lanes 0-1 of word 0 unchanged.
REQ-035 Back-to-back: store word 0xFBBF_FAAF @0x4 then load word @0x4 next cycle -> 0xFBBF_FAAF, Req_Ready high throughout.
REQ-036 Macro on: store word 0xAABB_CCDD @0x6, load word @0x6 -> 0xAABB_CCDD, Resp_Valid 2 cycles after accept, Req_Ready low 1 cycle; macro off: same store -> Misaligned_Err=1, words 1 and 2 unchanged.
REQ-037 Macro on, DEPTH_WORDS=4: store word 0x1234_5678 @0xE -> bytes 0x78,0x56 in word 3 lanes 2-3, 0x34,0x12 in word 0 lanes 0-1.
REQ-038 Assert RST low during SPLIT of REQ-036 -> no Resp_Valid, FSM IDLE, word 1 lanes 2-3 = 0xDD,0xCC, word 2 unchanged; full sweep writing i to every word 0..DEPTH_WORDS-1 reads back i.

Source files
------------

// File: rtl/dmem_banked.sv
// Data memory built from four byte-lane banks, with sign/zero-extending loads of byte, half and word.
// Define DMEM_MISALIGN_EN to split misaligned accesses over two cycles; otherwise they are rejected.
package dmem_banked_pkg;
  localparam logic [2:0] MEM_BYTE              = 3'b000;
  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;
endpackage

module dmem_banked
  import dmem_banked_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              MEM_W_En,
  input  logic [2:0]        MEM_Control,
  input  logic [ADDR_W-1:0] RW_Addr,
  input  logic [31:0]       W_Data,
  output logic [31:0]       R_Data,
  output logic              Resp_Valid,
  output logic              Misaligned_Err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  typedef logic [IdxW-1:0] idx_t;

`ifdef DMEM_MISALIGN_EN
  typedef enum logic [1:0] {StIdle, StSplit, StResp} state_e;
`else
  typedef enum logic [0:0] {StIdle, StResp} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] r_data_q, r_data_d;
  logic        err_q, err_d;

  logic [7:0]  bank_mem [4][DEPTH_WORDS];

  logic        accept, misaligned;
  logic [1:0]  off;
  idx_t        idx;
  logic [3:0]  base_mask, lo_mask;
  logic [5:0]  wr_shift;
  logic [31:0] rot_wdata, rd_lo;
  logic [3:0]  wr_en;
  idx_t        wr_idx;
  logic [31:0] wr_data;

  function automatic logic [3:0] size_mask(input logic [2:0] c);
    case (c)
      MEM_BYTE, MEM_BYTE_UNSIGNED:         size_mask = 4'b0001;
      MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: size_mask = 4'b0011;
      default:                             size_mask = 4'b1111;
    endcase
  endfunction

  // Rotate lanes back so the accessed bytes start at bit 0, then extend.
  function automatic logic [31:0] extend(input logic [31:0] lanes, input logic [1:0] o,
                                         input logic [2:0] c);
    logic [5:0]  sh;
    logic [31:0] raw;
    sh  = {1'b0, o, 3'b000};
    raw = (lanes >> sh) | (lanes << (6'd32 - sh));
    case (c)
      MEM_BYTE:              extend = {{24{raw[7]}}, raw[7:0]};
      MEM_BYTE_UNSIGNED:     extend = {24'h0, raw[7:0]};
      MEM_HALFWORD:          extend = {{16{raw[15]}}, raw[15:0]};
      MEM_HALFWORD_UNSIGNED: extend = {16'h0, raw[15:0]};
      default:               extend = raw;
    endcase
  endfunction

  assign off        = RW_Addr[1:0];
  assign idx        = RW_Addr[IdxW+1:2];
  assign base_mask  = size_mask(MEM_Control);
  assign misaligned = (base_mask[1] && off[0]) || (base_mask[3] && off[1]);
  assign wr_shift   = {1'b0, off, 3'b000};
  assign rot_wdata  = (W_Data << wr_shift) | (W_Data >> (6'd32 - wr_shift));
  assign accept     = Req_Valid && Req_Ready;

  if (ADDR_W > IdxW + 2) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^RW_Addr[ADDR_W-1:IdxW+2];
  end

  always_comb begin
    for (int k = 0; k < 4; k++) rd_lo[8*k +: 8] = bank_mem[k][idx];
  end

`ifdef DMEM_MISALIGN_EN
  // Lanes past the word boundary belong to the next word, finished in the split cycle.
  logic [3:0]  hi_mask;
  logic [3:0]  spl_mask_q, spl_mask_d;
  idx_t        spl_idx_q, spl_idx_d;
  logic [31:0] spl_wdata_q, spl_wdata_d;
  logic [31:0] spl_rd_q, spl_rd_d;
  logic        spl_load_q, spl_load_d;
  logic [2:0]  spl_ctrl_q, spl_ctrl_d;
  logic [1:0]  spl_off_q, spl_off_d;
  logic [31:0] rd_hi, merged;

  assign {hi_mask, lo_mask} = {4'b0000, base_mask} << off;
  assign Req_Ready          = RST && (state_q != StSplit);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_hi[8*k +: 8]  = bank_mem[k][spl_idx_q];
      merged[8*k +: 8] = spl_mask_q[k] ? rd_hi[8*k +: 8] : spl_rd_q[8*k +: 8];
    end
  end

  always_comb begin
    spl_mask_d  = spl_mask_q;
    spl_idx_d   = spl_idx_q;
    spl_wdata_d = spl_wdata_q;
    spl_rd_d    = spl_rd_q;
    spl_load_d  = spl_load_q;
    spl_ctrl_d  = spl_ctrl_q;
    spl_off_d   = spl_off_q;
    if (accept && misaligned) begin
      spl_mask_d  = hi_mask;
      spl_idx_d   = idx + idx_t'(1);
      spl_wdata_d = rot_wdata;
      spl_rd_d    = rd_lo;
      spl_load_d  = !MEM_W_En;
      spl_ctrl_d  = MEM_Control;
      spl_off_d   = off;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      spl_mask_q  <= '0;
      spl_idx_q   <= '0;
      spl_wdata_q <= '0;
      spl_rd_q    <= '0;
      spl_load_q  <= 1'b0;
      spl_ctrl_q  <= MEM_WORD;
      spl_off_q   <= '0;
    end else begin
      spl_mask_q  <= spl_mask_d;
      spl_idx_q   <= spl_idx_d;
      spl_wdata_q <= spl_wdata_d;
      spl_rd_q    <= spl_rd_d;
      spl_load_q  <= spl_load_d;
      spl_ctrl_q  <= spl_ctrl_d;
      spl_off_q   <= spl_off_d;
    end
  end
`else
  assign lo_mask   = base_mask << off;
  assign Req_Ready = RST;
`endif

  always_comb begin
    state_d  = StIdle;
    r_data_d = r_data_q;
    err_d    = 1'b0;
    wr_en    = '0;
    wr_idx   = idx;
    wr_data  = rot_wdata;
    if (accept) begin
      state_d = StResp;
      if (misaligned) begin
`ifdef DMEM_MISALIGN_EN
        state_d = StSplit;
        if (MEM_W_En) wr_en = lo_mask;
`else
        err_d    = 1'b1;
        r_data_d = '0;
`endif
      end else if (MEM_W_En) begin
        wr_en = lo_mask;
      end else begin
        r_data_d = extend(rd_lo, off, MEM_Control);
      end
    end
`ifdef DMEM_MISALIGN_EN
    if (state_q == StSplit) begin
      state_d = StResp;
      if (spl_load_q) begin
        r_data_d = extend(merged, spl_off_q, spl_ctrl_q);
      end else begin
        wr_en   = spl_mask_q;
        wr_idx  = spl_idx_q;
        wr_data = spl_wdata_q;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      r_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_data_q <= r_data_d;
      err_q    <= err_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) bank_mem[k][wr_idx] <= wr_data[8*k +: 8];
    end
  end

  assign Resp_Valid     = (state_q == StResp);
  assign Misaligned_Err = err_q;
  assign R_Data         = r_data_q;

endmodule

// File: tb/tb_dmem_banked.sv
// Self-checking bench for dmem_banked: byte-addressed reference model plus directed literal checks.
// Covers both builds; DMEM_MISALIGN_EN selects which misaligned behaviour is expected.
module tb_dmem_banked;
  import dmem_banked_pkg::*;

  localparam int unsigned Depth  = 4;
  localparam int unsigned NBytes = Depth * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        we = 1'b0;
  logic [2:0]  ctrl = MEM_WORD;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        mis_err;

  dmem_banked #(.DEPTH_WORDS(Depth), .ADDR_W(32)) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .Req_Valid     (req_valid),
    .Req_Ready     (req_ready),
    .MEM_W_En      (we),
    .MEM_Control   (ctrl),
    .RW_Addr       (addr),
    .W_Data        (wdata),
    .R_Data        (rdata),
    .Resp_Valid    (resp_valid),
    .Misaligned_Err(mis_err)
  );

  always #5 clk = ~clk;

  typedef struct {int due; bit is_load; bit err; logic [31:0] data;} exp_t;
  typedef struct {int unsigned b; logic [7:0] d;} pend_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          split_cyc = -1;
  logic [7:0]  mm [NBytes];
  exp_t        expq [$];
  pend_t       pend [$];
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int size_of(input logic [2:0] c);
    if (c == MEM_BYTE || c == MEM_BYTE_UNSIGNED) return 1;
    if (c == MEM_HALFWORD || c == MEM_HALFWORD_UNSIGNED) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] c);
    return (a % size_of(c)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < size_of(c); j++) v[8*j +: 8] = mm[(a + 32'(j)) % NBytes];
    if (c == MEM_BYTE) v = {{24{v[7]}}, v[7:0]};
    if (c == MEM_HALFWORD) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_accept(input bit w, input logic [2:0] c, input logic [31:0] a,
                              input logic [31:0] d);
    exp_t  e;
    pend_t p;
    bit    mis;
    mis       = is_mis(a, c);
    e.due     = cyc;
    e.is_load = !w;
    e.err     = 1'b0;
    e.data    = '0;
`ifdef DMEM_MISALIGN_EN
    if (mis) begin
      e.due     = cyc + 1;
      split_cyc = cyc;
    end
`else
    if (mis) e.err = 1'b1;
`endif
    if (!e.err) begin
      if (w) begin
        for (int j = 0; j < size_of(c); j++) begin
          p.b = (a + 32'(j)) % NBytes;
          p.d = d[8*j +: 8];
          // Bytes beyond the first word land one cycle later.
          if (mis && (int'(a % 4) + j) >= 4) pend.push_back(p);
          else mm[p.b] = p.d;
        end
      end else begin
        e.data = model_load(a, c);
      end
    end
    expq.push_back(e);
  endtask

  task automatic step(input bit v, input bit w, input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] d);
    bit acc;
    req_valid = v;
    we        = w;
    ctrl      = c;
    addr      = a;
    wdata     = d;
    acc       = v && rst_n && (cyc != split_cyc);
    @(posedge clk);
    if (cyc == split_cyc) begin
      foreach (pend[i]) mm[pend[i].b] = pend[i].d;
      pend.delete();
    end
    cyc++;
    if (acc) model_accept(w, c, a, d);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, MEM_WORD, 32'h0, 32'h0);
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    split_cyc = -1;
    pend.delete();
    expq.delete();
  endtask

  initial begin : compare
    exp_t e;
    bit   exp_resp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rd = '0;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp", 32'(resp_valid), 32'h0);
        check("rst_err", 32'(mis_err), 32'h0);
        check("rst_rdata", rdata, 32'h0);
      end else begin
        while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
        exp_resp = (expq.size() > 0) && (expq[0].due == cyc);
        check("ready", 32'(req_ready), 32'(cyc != split_cyc));
        check("resp_valid", 32'(resp_valid), 32'(exp_resp));
        if (exp_resp) begin
          e = expq.pop_front();
          check("mis_err", 32'(mis_err), 32'(e.err));
          if (e.is_load || e.err) last_rd = e.data;
        end else begin
          check("mis_err_idle", 32'(mis_err), 32'h0);
        end
        check("r_data", rdata, last_rd);
      end
    end
  end

  initial begin : drive
    #1 assert_reset();
    step(1'b1, 1'b1, MEM_WORD, 32'h0, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, MEM_WORD, 32'h0, 32'h0);
    check("rst_hold_resp", 32'(resp_valid), 32'h0);
    rst_n = 1'b1;

    // Sweep, then a reset that must leave memory intact.
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b1, MEM_WORD, 32'(4 * i), 32'(i));
    check("first_accept_resp", 32'(resp_valid), 32'h1);
    idle();
    assert_reset();
    idle();
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      step(1'b1, 1'b0, MEM_WORD, 32'(4 * i), 32'h0);
      check("sweep_rd", rdata, 32'(i));
    end
    idle();

    step(1'b1, 1'b1, MEM_BYTE, 32'h0, 32'h1111_11FF);
    step(1'b1, 1'b0, MEM_BYTE, 32'h0, 32'h0);
    check("lb_resp", 32'(resp_valid), 32'h1);
    check("lb", rdata, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, MEM_BYTE_UNSIGNED, 32'h0, 32'h0);
    check("lbu", rdata, 32'h0000_00FF);
    check("model_lb", model_load(32'h0, MEM_BYTE), 32'hFFFF_FFFF);

    step(1'b1, 1'b1, MEM_HALFWORD, 32'h2, 32'hF11F_F00F);
    step(1'b1, 1'b0, MEM_HALFWORD, 32'h2, 32'h0);
    check("lh", rdata, 32'hFFFF_F00F);
    step(1'b1, 1'b0, MEM_HALFWORD_UNSIGNED, 32'h2, 32'h0);
    check("lhu", rdata, 32'h0000_F00F);
    step(1'b1, 1'b0, MEM_HALFWORD_UNSIGNED, 32'h0, 32'h0);
    check("lhu_low_lanes", rdata, 32'h0000_00FF);
    step(1'b1, 1'b0, MEM_WORD, 32'h0, 32'h0);
    check("lw_word0", rdata, 32'hF00F_00FF);

    step(1'b1, 1'b1, MEM_WORD, 32'h4, 32'hFBBF_FAAF);
    check("b2b_ready", 32'(req_ready), 32'h1);
    step(1'b1, 1'b0, MEM_WORD, 32'h4, 32'h0);
    check("b2b_raw", rdata, 32'hFBBF_FAAF);
    idle();

    step(1'b1, 1'b1, MEM_WORD, 32'h6, 32'hAABB_CCDD);
`ifdef DMEM_MISALIGN_EN
    check("split_no_resp", 32'(resp_valid), 32'h0);
    check("split_not_ready", 32'(req_ready), 32'h0);
    idle();
    check("split_resp", 32'(resp_valid), 32'h1);
    step(1'b1, 1'b0, MEM_WORD, 32'h6, 32'h0);
    idle();
    check("split_lw", rdata, 32'hAABB_CCDD);
    step(1'b1, 1'b0, MEM_WORD, 32'h4, 32'h0);
    check("split_w1", rdata, 32'hCCDD_FAAF);
    step(1'b1, 1'b0, MEM_WORD, 32'h8, 32'h0);
    check("split_w2", rdata, 32'h0000_AABB);

    step(1'b1, 1'b1, MEM_WORD, 32'hE, 32'h1234_5678);
    idle();
    step(1'b1, 1'b0, MEM_BYTE_UNSIGNED, 32'hE, 32'h0);
    check("wrap_b14", rdata, 32'h78);
    step(1'b1, 1'b0, MEM_BYTE_UNSIGNED, 32'hF, 32'h0);
    check("wrap_b15", rdata, 32'h56);
    step(1'b1, 1'b0, MEM_BYTE_UNSIGNED, 32'h0, 32'h0);
    check("wrap_b0", rdata, 32'h34);
    step(1'b1, 1'b0, MEM_BYTE_UNSIGNED, 32'h1, 32'h0);
    check("wrap_b1", rdata, 32'h12);
    step(1'b1, 1'b0, MEM_WORD, 32'h0, 32'h0);
    check("wrap_w0", rdata, 32'hF00F_1234);

    // Accept in RESP straight into another split.
    step(1'b1, 1'b1, MEM_WORD, 32'h5, 32'h0102_0304);
    idle();
    step(1'b1, 1'b0, MEM_HALFWORD, 32'h7, 32'h0);
    idle();
    check("b2b_split_lh", rdata, 32'h0000_0102);

    step(1'b1, 1'b1, MEM_WORD, 32'h4, 32'h0);
    step(1'b1, 1'b1, MEM_WORD, 32'h8, 32'h2222_2222);
    step(1'b1, 1'b1, MEM_WORD, 32'h6, 32'hAABB_CCDD);
    #2 assert_reset();
    #1 check("abort_resp", 32'(resp_valid), 32'h0);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    step(1'b1, 1'b0, MEM_WORD, 32'h4, 32'h0);
    check("abort_w1", rdata, 32'hCCDD_0000);
    step(1'b1, 1'b0, MEM_WORD, 32'h8, 32'h0);
    check("abort_w2", rdata, 32'h2222_2222);
`else
    check("mis_err_pulse", 32'(mis_err), 32'h1);
    check("mis_rdata", rdata, 32'h0);
    step(1'b1, 1'b0, MEM_WORD, 32'h4, 32'h0);
    check("mis_w1_kept", rdata, 32'hFBBF_FAAF);
    step(1'b1, 1'b0, MEM_WORD, 32'h8, 32'h0);
    check("mis_w2_kept", rdata, 32'h2);
    step(1'b1, 1'b0, MEM_HALFWORD, 32'h1, 32'h0);
    check("mis_lh_err", 32'(mis_err), 32'h1);
    step(1'b1, 1'b1, MEM_WORD, 32'hE, 32'h1234_5678);
    check("mis_wrap_err", 32'(mis_err), 32'h1);
    step(1'b1, 1'b0, MEM_WORD, 32'hC, 32'h0);
    check("mis_w3_kept", rdata, 32'h3);
    step(1'b1, 1'b0, MEM_WORD, 32'h0, 32'h0);
    check("mis_w0_kept", rdata, 32'hF00F_00FF);

    step(1'b1, 1'b0, MEM_WORD, 32'h8, 32'h0);
    assert_reset();
    #1 check("rst_in_resp", 32'(resp_valid), 32'h0);
    check("rst_in_resp_rd", rdata, 32'h0);
    idle();
    rst_n = 1'b1;
    idle();
`endif

    // Upper address bits are ignored.
    step(1'b1, 1'b1, MEM_BYTE, 32'hFFFF_FFF3, 32'h0000_005A);
    step(1'b1, 1'b0, MEM_BYTE_UNSIGNED, 32'h3, 32'h0);
    check("alias_byte", rdata, 32'h5A);
    step(1'b1, 1'b0, MEM_WORD, 32'h10, 32'h0);
    idle();
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
